// File: rtl/gemm_drain_pkg.sv
// Shared types for the GEMM result drain: FSM state encoding, default
// geometry of a PE row, and the packed type carrying the PE accumulators.
package gemm_drain_pkg;

    localparam int unsigned NUM_PE     = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } drain_state_e;

    // Element 0 sits in the least significant word and is drained first.
    typedef logic signed [NUM_PE-1:0][DATA_WIDTH-1:0] pe_c_t;

endpackage : gemm_drain_pkg

// File: rtl/gemm_result_drain_if.sv
// Valid/ready write port from the result drain towards the result SRAM or
// writeback path. The master drives the word, the slave grants acceptance.
interface gemm_result_drain_if
    import gemm_drain_pkg::*;
#(
    parameter int unsigned AddrWidth = ADDR_WIDTH,
    parameter int unsigned DataWidth = DATA_WIDTH
);

    logic                 wr_valid_o;
    logic                 wr_ready_i;
    logic [AddrWidth-1:0] wr_addr_o;
    logic [DataWidth-1:0] wr_data_o;

    modport master (
        output wr_valid_o,
        output wr_addr_o,
        output wr_data_o,
        input  wr_ready_i
    );

    modport slave (
        input  wr_valid_o,
        input  wr_addr_o,
        input  wr_data_o,
        output wr_ready_i
    );

endinterface : gemm_result_drain_if

// File: rtl/gemm_result_drain.sv
// Snapshots the accumulators of a PE row in one cycle, pulses their clear,
// then streams the captured words one per handshake to a write port with a
// programmable base address and stride. The PEs are free to start the next
// tile as soon as the snapshot is taken.
module gemm_result_drain
    import gemm_drain_pkg::*;
#(
    parameter int unsigned NumPE     = NUM_PE,
    parameter int unsigned DataWidth = DATA_WIDTH,
    parameter int unsigned AddrWidth = ADDR_WIDTH
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    start_i,
    input  logic        [AddrWidth-1:0]             base_addr_i,
    input  logic        [AddrWidth-1:0]             stride_i,
    input  logic signed [NumPE-1:0][DataWidth-1:0]  pe_c_i,
    output logic                                    acc_clr_o,
    output logic                                    busy_o,
    output logic                                    done_o,
    gemm_result_drain_if.master                     wr
);

    // A single-PE row still needs a one-bit index so the select is legal.
    localparam int unsigned IdxWidth = (NumPE > 1) ? $clog2(NumPE) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumPE - 1);

    drain_state_e state_r;
    drain_state_e state_nxt_s;

    logic [NumPE-1:0][DataWidth-1:0] buf_r;
    logic [IdxWidth-1:0]             idx_r;
    logic [AddrWidth-1:0]            addr_r;
    logic [AddrWidth-1:0]            stride_r;

    logic acc_clr_r;
    logic busy_r;
    logic done_r;
    logic wr_valid_r;

    logic start_acc_s;
    logic hs_s;
    logic last_s;

    // Qualify the start request and the write handshake from registered state.
    always_comb begin
        start_acc_s = 1'b0;
        hs_s        = 1'b0;
        last_s      = (idx_r == LastIdx);
        if (state_r == IDLE) begin
            start_acc_s = start_i;
        end else if (state_r == SEND) begin
            hs_s = wr.wr_ready_i;
        end else begin
            start_acc_s = 1'b0;
            hs_s        = 1'b0;
        end
    end

    // Next-state decode: start is only honoured in IDLE and never queued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (hs_s && last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_clr_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wr_valid_r <= 1'b0;
        end else begin
            acc_clr_r  <= start_acc_s;
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= (state_nxt_s == DONE);
            wr_valid_r <= (state_nxt_s == SEND);
        end
    end

    // Snapshot buffer, word index and address accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_r    <= '0;
            idx_r    <= '0;
            addr_r   <= '0;
            stride_r <= '0;
        end else if (start_acc_s) begin
            buf_r    <= pe_c_i;
            idx_r    <= '0;
            addr_r   <= base_addr_i;
            stride_r <= stride_i;
        end else if (hs_s) begin
            // Address wraps naturally at the port width.
            addr_r <= addr_r + stride_r;
            // The index parks on the last word so it never selects past the
            // buffer; the next start reloads it anyway.
            if (!last_s) begin
                idx_r <= idx_r + {{(IdxWidth-1){1'b0}}, 1'b1};
            end else begin
                idx_r <= idx_r;
            end
        end else begin
            buf_r    <= buf_r;
            idx_r    <= idx_r;
            addr_r   <= addr_r;
            stride_r <= stride_r;
        end
    end

    assign acc_clr_o     = acc_clr_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign wr.wr_valid_o = wr_valid_r;
    assign wr.wr_addr_o  = addr_r;
    assign wr.wr_data_o  = buf_r[idx_r];

endmodule : gemm_result_drain
